// File: rtl/cond_pkg.sv
// Shared types for the condflow conditional source: FSM state encoding and synchronizer depth.
package cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        REQ     = 2'd2,
        ACK     = 2'd3
    } cond_src_state_t;

    localparam int unsigned COND_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_sync2.sv
// Single-bit multi-flop synchronizer for handshake request/ack lines, synchronous active-high reset.
module hs_sync2
    import cond_pkg::*;
#(
    parameter int unsigned STAGES = COND_SYNC_STAGES  // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cond_source2.sv
// Conditional source: dctl=1 forwards one input token, dctl=0 emits DEFAULT without consuming input.
// Define COND_SOURCE2_SYNC_EN to pass r_i, rctl_i and a_o through 2-flop synchronizers.
module cond_source2
    import cond_pkg::*;
#(
    parameter int unsigned  N       = 1,
    parameter logic [N-1:0] DEFAULT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [N-1:0] d_i,
    input  logic         rctl_i,
    input  logic         dctl_i,
    output logic         actl_i,
    output logic         r_o,
    input  logic         a_o,
    output logic [N-1:0] d_o
);

    logic r_s;
    logic rctl_s;
    logic a_o_s;

`ifdef COND_SOURCE2_SYNC_EN
    hs_sync2 #(.STAGES(COND_SYNC_STAGES)) u_sync_r (
        .clk (clk),
        .rst (rst),
        .d_i (r_i),
        .q_o (r_s)
    );

    hs_sync2 #(.STAGES(COND_SYNC_STAGES)) u_sync_rctl (
        .clk (clk),
        .rst (rst),
        .d_i (rctl_i),
        .q_o (rctl_s)
    );

    hs_sync2 #(.STAGES(COND_SYNC_STAGES)) u_sync_a_o (
        .clk (clk),
        .rst (rst),
        .d_i (a_o),
        .q_o (a_o_s)
    );
`else
    assign r_s    = r_i;
    assign rctl_s = rctl_i;
    assign a_o_s  = a_o;
`endif

    cond_src_state_t state_q, state_d;
    logic            sel_q, sel_d;
    logic [N-1:0]    data_q, data_d;
    logic            r_o_q, r_o_d;
    logic            a_i_q, a_i_d;
    logic            actl_q, actl_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        r_o_d   = r_o_q;
        a_i_d   = a_i_q;
        actl_d  = actl_q;

        unique case (state_q)
            IDLE: begin
                // a_o must be low so the previous consumer handshake has fully returned to zero
                if (rctl_s && !a_o_s) begin
                    sel_d = dctl_i;
                    if (!dctl_i) begin
                        data_d  = DEFAULT;
                        r_o_d   = 1'b1;
                        state_d = REQ;
                    end else if (r_s) begin
                        data_d  = d_i;
                        r_o_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = WAIT_IN;
                    end
                end
            end
            WAIT_IN: begin
                if (r_s) begin
                    data_d  = d_i;
                    r_o_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (a_o_s) begin
                    r_o_d   = 1'b0;
                    actl_d  = 1'b1;
                    a_i_d   = sel_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                // A generated token leaves any pending r_i untouched, so only wait on it when passing
                if (!rctl_s && !a_o_s && (!sel_q || !r_s)) begin
                    actl_d  = 1'b0;
                    a_i_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            data_q  <= DEFAULT;
            r_o_q   <= 1'b0;
            a_i_q   <= 1'b0;
            actl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            r_o_q   <= r_o_d;
            a_i_q   <= a_i_d;
            actl_q  <= actl_d;
        end
    end

    assign r_o    = r_o_q;
    assign a_i    = a_i_q;
    assign actl_i = actl_q;
    assign d_o    = data_q;

endmodule
